// File: rtl/fmc_master.sv
// FMC initiator for a multiplexed-address/data asynchronous bus (NE1/NADV/NWE/NOE, 16-bit AD).
// Single outstanding request; one 8-bit down-counter times every bus phase.
module fmc_master #(
   parameter int unsigned ADDSET  = 2,
   parameter int unsigned ADDHLD  = 1,
   parameter int unsigned DATAST  = 4,
   parameter int unsigned BUSTURN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic        fpga_cs_ne1,
   output logic        fpga_nl_nadv,
   output logic        fpga_wr_nwe,
   output logic        fpga_rd_noe,
   inout  wire  [15:0] fpga_db
);

   typedef enum logic [2:0] {StIdle, StAddr, StAhold, StData, StTurn} state_e;

   localparam logic [7:0] AddsetM1  = 8'(ADDSET - 1);
   localparam logic [7:0] AddhldM1  = 8'(ADDHLD - 1);
   localparam logic [7:0] DatastM1  = 8'(DATAST - 1);
   localparam logic [7:0] BusturnM1 = 8'(BUSTURN - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        rsp_q, rsp_d;
   logic        ne1_q, ne1_d;
   logic        nadv_q, nadv_d;
   logic        nwe_q, nwe_d;
   logic        noe_q, noe_d;
   logic        oe_q, oe_d;
   logic [15:0] ad_q, ad_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 8'd1;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rsp_d   = 1'b0;

      case (state_q)
         StIdle: begin
            cnt_d = cnt_q;
            if (req_valid) begin
               state_d = StAddr;
               cnt_d   = AddsetM1;
               wr_d    = req_wr;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end
         end
         StAddr: begin
            if (cnt_q == 8'd0) begin
               state_d = StAhold;
               cnt_d   = AddhldM1;
            end
         end
         StAhold: begin
            if (cnt_q == 8'd0) begin
               state_d = StData;
               cnt_d   = DatastM1;
            end
         end
         StData: begin
            if (cnt_q == 8'd0) begin
               state_d = StTurn;
               cnt_d   = BusturnM1;
               rsp_d   = 1'b1;
               // Last DATA edge: slave read data has been stable for DATAST-1 cycles.
               if (!wr_q) rdata_d = fpga_db;
            end
         end
         StTurn: begin
            if (cnt_q == 8'd0) begin
               state_d = StIdle;
               cnt_d   = 8'd0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase

      // Bus pins are registered from the next state so they switch with the state flop.
      ne1_d  = !(state_d inside {StAddr, StAhold, StData});
      nadv_d = (state_d != StAddr);
      nwe_d  = !((state_d == StData) && wr_d);
      noe_d  = !((state_d == StData) && !wr_d);
      oe_d   = (state_d inside {StAddr, StAhold}) || ((state_d == StData) && wr_d);
      ad_d   = (state_d == StData) ? wdata_d : addr_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         wr_q    <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         rsp_q   <= 1'b0;
         ne1_q   <= 1'b1;
         nadv_q  <= 1'b1;
         nwe_q   <= 1'b1;
         noe_q   <= 1'b1;
         oe_q    <= 1'b0;
         ad_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rsp_q   <= rsp_d;
         ne1_q   <= ne1_d;
         nadv_q  <= nadv_d;
         nwe_q   <= nwe_d;
         noe_q   <= noe_d;
         oe_q    <= oe_d;
         ad_q    <= ad_d;
      end
   end

   assign req_ready    = (state_q == StIdle);
   assign busy         = (state_q != StIdle);
   assign rsp_valid    = rsp_q;
   assign rsp_rdata    = rdata_q;
   assign fpga_cs_ne1  = ne1_q;
   assign fpga_nl_nadv = nadv_q;
   assign fpga_wr_nwe  = nwe_q;
   assign fpga_rd_noe  = noe_q;
   assign fpga_db      = oe_q ? ad_q : 16'hzzzz;

endmodule

// File: tb/tb_fmc_master.sv
// Directed bench for fmc_master: default-timing instance plus a minimum-timing instance,
// each on its own bus with a small behavioural FMC slave.
module tb_fmc_master;

   localparam logic [15:0] ZPULL = 16'hFFFF;  // undriven bus reads as pulled high

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Default-timing DUT
   logic        req_valid = 1'b0, req_wr = 1'b0;
   logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
   logic        req_ready, rsp_valid, busy, ne1, nadv, nwe, noe;
   logic [15:0] rsp_rdata;
   tri1  [15:0] db;

   fmc_master u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .busy(busy), .fpga_cs_ne1(ne1), .fpga_nl_nadv(nadv),
      .fpga_wr_nwe(nwe), .fpga_rd_noe(noe), .fpga_db(db)
   );

   // Minimum-timing DUT
   logic        f_req_valid = 1'b0, f_req_wr = 1'b0;
   logic [15:0] f_req_addr = 16'h0, f_req_wdata = 16'h0;
   logic        f_req_ready, f_rsp_valid, f_busy, f_ne1, f_nadv, f_nwe, f_noe;
   logic [15:0] f_rsp_rdata;
   tri1  [15:0] f_db;

   fmc_master #(.ADDSET(1), .ADDHLD(1), .DATAST(2), .BUSTURN(1)) u_fast (
      .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready),
      .req_wr(f_req_wr), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
      .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
      .fpga_cs_ne1(f_ne1), .fpga_nl_nadv(f_nadv), .fpga_wr_nwe(f_nwe), .fpga_rd_noe(f_noe),
      .fpga_db(f_db)
   );

   // Slave models: latch address while NADV low, capture writes while NWE low,
   // drive read data while NOE low (optionally looping written data back).
   logic [15:0] wr_mem [16];
   logic [15:0] rd_mem [16];
   logic [15:0] lat;
   logic        loopback = 1'b0;
   logic [15:0] f_rd_mem [16];
   logic [15:0] f_lat;

   always @(posedge clk) begin
      if (!ne1 && !nadv) lat <= db;
      if (!ne1 && !nwe) wr_mem[lat[3:0]] <= db;
      if (!f_ne1 && !f_nadv) f_lat <= f_db;
   end

   assign db   = (!ne1 && !noe) ? (loopback ? wr_mem[lat[3:0]] : rd_mem[lat[3:0]]) : 16'hzzzz;
   assign f_db = (!f_ne1 && !f_noe) ? f_rd_mem[f_lat[3:0]] : 16'hzzzz;

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({ne1, nadv, nwe, noe} !== 4'hF) begin
         fails++; $display("FAIL reset_strobes: got %b, want 1111", {ne1, nadv, nwe, noe});
      end
      tests++;
      if (db !== ZPULL) begin fails++; $display("FAIL reset_db: got %h, want %h", db, ZPULL); end
      tests++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL reset_ready_busy: got %b%b, want 10", req_ready, busy);
      end
      tests++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000) begin
         fails++; $display("FAIL reset_rsp: got %b/%h, want 0/0000", rsp_valid, rsp_rdata);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      int nadv_lo = 0, addr_ok = 0, hold = 0, nwe_lo = 0, data_ok = 0;
      int ne1_lo = 0, busy_n = 0, rsp_n = 0, rsp_at = -1;
      req_wr = 1'b1; req_addr = 16'h0003; req_wdata = 16'hA55A; req_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         // Changing the request after acceptance must not affect the access.
         req_valid = 1'b0; req_addr = 16'h000F; req_wdata = 16'h0000;
         if (!nadv) begin nadv_lo++; if (db == 16'h0003) addr_ok++; end
         if (!ne1 && nadv && nwe && noe) hold++;
         if (!nwe) begin nwe_lo++; if (db == 16'hA55A) data_ok++; end
         if (!ne1) ne1_lo++;
         if (busy) busy_n++;
         if (rsp_valid) begin rsp_n++; if (rsp_at < 0) rsp_at = i; end
      end
      tests++;
      if (nadv_lo !== 2 || addr_ok !== 2) begin
         fails++; $display("FAIL wr_addr_phase: got %0d/%0d, want 2/2", nadv_lo, addr_ok);
      end
      tests++;
      if (hold !== 1) begin fails++; $display("FAIL wr_hold: got %0d, want 1", hold); end
      tests++;
      if (nwe_lo !== 4 || data_ok !== 4) begin
         fails++; $display("FAIL wr_data_phase: got %0d/%0d, want 4/4", nwe_lo, data_ok);
      end
      tests++;
      if (ne1_lo !== 7 || busy_n !== 8) begin
         fails++; $display("FAIL wr_occupancy: got ne1 %0d busy %0d, want 7 8", ne1_lo, busy_n);
      end
      tests++;
      if (rsp_n !== 1 || rsp_at !== 7) begin
         fails++; $display("FAIL wr_rsp: got %0d at %0d, want 1 at 7", rsp_n, rsp_at);
      end
      tests++;
      if (wr_mem[3] !== 16'hA55A) begin
         fails++; $display("FAIL wr_slave_data: got %h, want a55a", wr_mem[3]);
      end
      tests++;
      if (rsp_rdata !== 16'h0000) begin
         fails++; $display("FAIL wr_rdata_hold: got %h, want 0000", rsp_rdata);
      end
   endtask

   task automatic test_read();
      int noe_lo = 0, data_ok = 0, nwe_lo = 0, rsp_n = 0;
      logic [15:0] got = 16'h0;
      rd_mem[10] = 16'h1234;
      req_wr = 1'b0; req_addr = 16'h000A; req_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (!noe) begin noe_lo++; if (db == 16'h1234) data_ok++; end
         if (!nwe) nwe_lo++;
         if (rsp_valid) begin rsp_n++; got = rsp_rdata; end
      end
      tests++;
      if (noe_lo !== 4 || nwe_lo !== 0) begin
         fails++; $display("FAIL rd_strobes: got noe %0d nwe %0d, want 4 0", noe_lo, nwe_lo);
      end
      tests++;
      if (data_ok !== 4) begin
         fails++; $display("FAIL rd_bus_contention: got %0d clean cycles, want 4", data_ok);
      end
      tests++;
      if (rsp_n !== 1 || got !== 16'h1234) begin
         fails++; $display("FAIL rd_rsp: got %0d pulses data %h, want 1 1234", rsp_n, got);
      end
   endtask

   task automatic test_back_to_back();
      int acc_t[2];
      int n_acc = 0, rsp_n = 0, rdy_hi = 0, c = 0;
      loopback = 1'b1;
      req_wr = 1'b1; req_addr = 16'h0001; req_wdata = 16'hBEEF; req_valid = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (n_acc < 2 && req_valid && req_ready) begin acc_t[n_acc] = c; n_acc++; end
         @(negedge clk);
         c++;
         if (n_acc == 1) begin req_wr = 1'b0; req_wdata = 16'h0000; end
         if (n_acc == 2) req_valid = 1'b0;
         if (rsp_valid) rsp_n++;
         if (req_ready && (n_acc == 1 || (n_acc == 2 && c <= acc_t[1] + 8))) rdy_hi++;
      end
      loopback = 1'b0;
      tests++;
      if (n_acc !== 2 || acc_t[1] - acc_t[0] !== 9) begin
         fails++; $display("FAIL b2b_period: got %0d accepts gap %0d, want 2 gap 9",
                           n_acc, acc_t[1] - acc_t[0]);
      end
      tests++;
      if (rdy_hi !== 1) begin
         fails++; $display("FAIL b2b_ready_low: got %0d ready cycles, want 1", rdy_hi);
      end
      tests++;
      if (rsp_n !== 2 || rsp_rdata !== 16'hBEEF) begin
         fails++; $display("FAIL b2b_rsp: got %0d pulses data %h, want 2 beef", rsp_n, rsp_rdata);
      end
      tests++;
      if (wr_mem[1] !== 16'hBEEF) begin
         fails++; $display("FAIL b2b_slave_data: got %h, want beef", wr_mem[1]);
      end
   endtask

   task automatic test_reset_abort();
      int rsp_n = 0, rd_rsp = 0;
      logic [15:0] got = 16'h0;
      rd_mem[2] = 16'h5A5A;
      req_wr = 1'b1; req_addr = 16'h0004; req_wdata = 16'h1111; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (rsp_valid) rsp_n++;
      end
      tests++;
      if (nwe !== 1'b0 || db !== 16'h1111) begin
         fails++; $display("FAIL abort_in_data: got nwe %b db %h, want 0 1111", nwe, db);
      end
      rst = 1'b0;
      #1;
      tests++;
      if ({ne1, nadv, nwe, noe} !== 4'hF || db !== ZPULL) begin
         fails++; $display("FAIL abort_async: got %b db %h, want 1111 db %h",
                           {ne1, nadv, nwe, noe}, db, ZPULL);
      end
      repeat (2) begin @(negedge clk); if (rsp_valid) rsp_n++; end
      rst = 1'b1;
      repeat (3) begin @(negedge clk); if (rsp_valid) rsp_n++; end
      tests++;
      if (rsp_n !== 0) begin fails++; $display("FAIL abort_no_rsp: got %0d, want 0", rsp_n); end
      req_wr = 1'b0; req_addr = 16'h0002; req_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (rsp_valid) begin rd_rsp++; got = rsp_rdata; end
      end
      tests++;
      if (rd_rsp !== 1 || got !== 16'h5A5A) begin
         fails++; $display("FAIL abort_next_read: got %0d pulses %h, want 1 5a5a", rd_rsp, got);
      end
   endtask

   task automatic test_param_sweep();
      int busy_n = 0, nadv_lo = 0, noe_lo = 0, rsp_at = -1;
      logic [15:0] got = 16'h0;
      f_rd_mem[5] = 16'h00FF;
      f_req_wr = 1'b0; f_req_addr = 16'h0005; f_req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         f_req_valid = 1'b0;
         if (f_busy) busy_n++;
         if (!f_nadv) nadv_lo++;
         if (!f_noe) noe_lo++;
         if (f_rsp_valid && rsp_at < 0) begin rsp_at = i; got = f_rsp_rdata; end
      end
      tests++;
      if (busy_n !== 5) begin fails++; $display("FAIL sweep_occupancy: got %0d, want 5", busy_n); end
      tests++;
      if (nadv_lo !== 1 || noe_lo !== 2) begin
         fails++; $display("FAIL sweep_phases: got nadv %0d noe %0d, want 1 2", nadv_lo, noe_lo);
      end
      tests++;
      if (rsp_at !== 4 || got !== 16'h00FF) begin
         fails++; $display("FAIL sweep_rsp: got at %0d data %h, want at 4 00ff", rsp_at, got);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_abort();
      test_param_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/fmc_master.md
Name: fmc_master

Overview:
- Synthesizable FMC initiator for an asynchronous multiplexed-address/data NOR/PSRAM-style bus: NE1, NADV, NWE, NOE, 16-bit AD.
- Mimics the STM32 side of the FPGA FMC slave (fmc_control), so the FPGA can drive FMC-attached peripherals or a second FPGA.
- Also serves as a loopback master against fmc_control in board self-test.
- User side is a single-outstanding valid/ready request port with a response pulse.

Parameters:
- ADDSET, 2, address phase length in clk cycles (NADV low); legal 1..255.
- ADDHLD, 1, address hold after NADV rises, before strobes assert; legal 1..255.
- DATAST, 4, data phase length (NWE/NOE low); legal 2..255. Minimum 2 because the slave registers read data one cycle after its read enable.
- BUSTURN, 1, idle cycles with NE1 high and AD tri-stated after each access; legal 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready at posedge clk
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  16  bus address
- req_wdata  input  16  write data
- rsp_valid  output  1  one-cycle pulse on access completion (read and write)
- rsp_rdata  output  16  read data; updated only by reads, holds otherwise
- busy  output  1  high from accept until return to IDLE
- fpga_cs_ne1  output  1  chip select, active low
- fpga_nl_nadv  output  1  address valid, active low
- fpga_wr_nwe  output  1  write strobe, active low
- fpga_rd_noe  output  1  read strobe, active low
- fpga_db  inout  16  multiplexed address/data

Behaviour:
- Reset (async, rst low):
  - State IDLE; NE1, NADV, NWE, NOE = 1; fpga_db = Z.
  - rsp_valid = 0, rsp_rdata = 0, busy = 0; captured request registers = 0.
- All bus strobes and the AD output enable come straight from flops, so they are glitch-free. A single 8-bit down-counter times every phase.
- req_ready = (state == IDLE), combinational from state. Accept captures req_wr, req_addr, req_wdata; later req_* changes are ignored.
- States:
  - IDLE: strobes high, AD = Z. On accept: go to ADDR, counter = ADDSET-1.
  - ADDR: NE1 = 0, NADV = 0, AD driven with the captured address. At counter 0: go to AHOLD, counter = ADDHLD-1.
  - AHOLD: NE1 = 0, NADV = 1, AD still driven with the address. At counter 0: go to DATA, counter = DATAST-1.
  - DATA, write: NWE = 0, AD = wdata.
  - DATA, read: NOE = 0, AD = Z.
  - DATA exit, at counter 0:
    - A read samples fpga_db into rsp_rdata on this same clock edge (last DATA cycle).
    - Go to TURN, counter = BUSTURN-1; rsp_valid = 1 for exactly the first TURN cycle.
  - TURN: NE1 = 1, NADV = 1, NWE = 1, NOE = 1, AD = Z. At counter 0: go to IDLE.
- Cycle counts:
  - Each phase lasts exactly its parameter value in cycles.
  - Access occupancy is ADDSET+ADDHLD+DATAST+BUSTURN cycles (8 with defaults), then at least 1 IDLE cycle.
  - Minimum request-to-request period is that sum + 1 (9 with defaults).
- AD direction:
  - The master never drives AD while NOE = 0.
  - The output enable drops in the same cycle the state leaves DATA-write for TURN, so no overlap with the slave.
- A request held during busy is simply not accepted until IDLE. There is no queue and no drop.
- Address 16 bits, passed unmodified: no increment, no wrap, no decode.
- Reset mid-operation: all strobes return high and AD goes Z asynchronously, with no rsp_valid pulse for the aborted access. The first request after reset release is accepted in IDLE normally.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-run -> NE1/NADV/NWE/NOE = 1, fpga_db = Z, req_ready = 1, rsp_valid = 0, rsp_rdata = 0000.
- Write with defaults: req addr 0003, wdata A55A -> NADV low 2 cycles with AD = 0003; 1 hold cycle; NWE low 4 cycles with AD = A55A; rsp_valid at cycle 8; fmc_control read_data_3_ = A55A.
- Read with defaults: fmc_control write_data_10_ = 1234, req read addr 000A -> NOE low 4 cycles with AD not driven by master; rsp_valid with rsp_rdata = 1234.
- Back-to-back: write 0001←BEEF with req_valid held, then read 0001 looped to write_data_1_ -> second accept exactly 9 cycles after the first; rsp_rdata = BEEF; req_ready low during both accesses.
- Reset abort: assert rst during the 2nd DATA cycle of a write -> strobes high and AD = Z immediately, no rsp_valid; next read of addr 0002 completes normally.
- Parameter sweep: ADDSET=1, ADDHLD=1, DATAST=2, BUSTURN=1 -> 5-cycle occupancy; read of 0005 returns write_data_5_ = 00FF.
